// File: rtl/parity_pkg.sv
// Shared types and constants for the parity serializer: FSM state encoding,
// frame geometry and the parity-mismatch helper.
package parity_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam int   FRAME_BITS = 11;
  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;

  // High when the upstream parity bit disagrees with the one implied by the byte.
  function automatic logic parity_mismatch(input logic [7:0] d, input logic p,
                                           input logic odd);
    return p ^ (^d) ^ odd;
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Counts clocks within one serial bit; tick_o marks the last clock of the bit.
// The count is held at zero whenever the timer is disabled.
module bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic tick_o
);

  localparam int            CW   = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/parity_serializer.sv
// Serializes a byte as start, 8 data bits (LSB first), parity and stop bits,
// each held BIT_CYCLES clocks, and flags upstream parity disagreement.
module parity_serializer
  import parity_pkg::*;
#(
  parameter bit PARITY_ODD = 1'b0,
  parameter int BIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       par_even,
  input  logic       par_odd,
  output logic       tx,
  output logic       busy,
  output logic       done,
  output logic       par_err
);

  // Handshake: a frame is accepted on any rising edge with start=1 while idle,
  // or on the edge that ends a stop bit; start is ignored at all other times.

  state_t     state_q;
  logic       tx_q;
  logic       busy_q;
  logic       done_q;
  logic       par_err_q;
  logic       par_bit_q;
  logic [7:0] shift_q;
  logic [2:0] bit_idx_q;
  logic       tick;
  logic       sel_par_d;
  logic       par_err_d;

  assign sel_par_d = PARITY_ODD ? par_odd : par_even;
  assign par_err_d = parity_mismatch(data_in, sel_par_d, PARITY_ODD);

  bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (busy_q),
    .tick_o (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      par_err_q <= 1'b0;
      par_bit_q <= 1'b0;
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_START;
            tx_q      <= START_BIT;
            busy_q    <= 1'b1;
            shift_q   <= data_in;
            par_bit_q <= sel_par_d;
            par_err_q <= par_err_d;
            bit_idx_q <= '0;
          end
        end
        S_START: begin
          if (tick) begin
            state_q   <= S_DATA;
            tx_q      <= shift_q[0];
            shift_q   <= shift_q >> 1;
            bit_idx_q <= '0;
          end
        end
        S_DATA: begin
          if (tick) begin
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              state_q <= S_PARITY;
              tx_q    <= par_bit_q;
            end else begin
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state_q <= S_STOP;
            tx_q    <= STOP_BIT;
          end
        end
        S_STOP: begin
          if (tick) begin
            done_q <= 1'b1;
            // A waiting request chains straight into the next start bit.
            if (start) begin
              state_q   <= S_START;
              tx_q      <= START_BIT;
              shift_q   <= data_in;
              par_bit_q <= sel_par_d;
              par_err_q <= par_err_d;
              bit_idx_q <= '0;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= STOP_BIT;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign par_err = par_err_q;

endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer: two instances (even parity / 4 clocks per bit,
// odd parity / 2 clocks per bit) driven from a vector table, corner sequences and random frames.
module tb_parity_serializer;
  import parity_pkg::*;

  localparam int BC0 = 4;
  localparam int BC1 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0] start_v, pe_v, po_v;
  logic [7:0] data_v [2];
  logic [1:0] tx_v, busy_v, done_v, err_v;

  parity_serializer #(.PARITY_ODD(1'b0), .BIT_CYCLES(BC0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .data_in(data_v[0]),
    .par_even(pe_v[0]), .par_odd(po_v[0]), .tx(tx_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .par_err(err_v[0]));

  parity_serializer #(.PARITY_ODD(1'b1), .BIT_CYCLES(BC1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .data_in(data_v[1]),
    .par_even(pe_v[1]), .par_odd(po_v[1]), .tx(tx_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .par_err(err_v[1]));

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int bc_of(input int sel);
    return (sel != 0) ? BC1 : BC0;
  endfunction

  function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic pb);
    return {STOP_BIT, pb, d, START_BIT};
  endfunction

  function automatic logic model_pb(input int sel, input logic pe, input logic po);
    return (sel != 0) ? po : pe;
  endfunction

  function automatic logic model_err(input int sel, input logic [7:0] d,
                                     input logic pe, input logic po);
    int ones;
    logic right_bit;
    ones = $countones(d);
    right_bit = (sel != 0) ? logic'((ones % 2) == 0) : logic'((ones % 2) == 1);
    return model_pb(sel, pe, po) != right_bit;
  endfunction

  // ---------------- driver tasks ----------------
  // Called at a falling edge; the request is taken on the next rising edge.
  task automatic send(input int sel, input logic [7:0] d, input logic pe, input logic po);
    start_v[sel] = 1'b1;
    data_v[sel]  = d;
    pe_v[sel]    = pe;
    po_v[sel]    = po;
    @(negedge clk);
    start_v[sel] = 1'b0;
  endtask

  // Starts at the first falling edge after accept, returns at the falling edge
  // where done is expected.
  task automatic watch_frame(input int sel, input logic [7:0] d, input logic pb,
                             input logic exp_err, input int pulse_at, input bit b2b);
    logic [10:0] bits;
    int bc, bad_tx, bad_ctl, first_bad;
    bits = frame_bits(d, pb);
    bc = bc_of(sel);
    bad_tx = 0;
    bad_ctl = 0;
    first_bad = -1;
    for (int k = 0; k < FRAME_BITS * bc; k++) begin
      if (tx_v[sel] !== bits[k / bc]) begin
        bad_tx++;
        if (first_bad < 0) first_bad = k;
      end
      if (busy_v[sel] !== 1'b1 || done_v[sel] !== logic'(b2b && k == 0)) bad_ctl++;
      if (k == 0) chk("par_err", err_v[sel], exp_err);
      if (pulse_at >= 0) begin
        start_v[sel] = (k == pulse_at);
        data_v[sel]  = 8'($urandom);
      end
      @(negedge clk);
    end
    if (bad_tx != 0) $display("  first tx miss at clock %0d of frame %02h", first_bad, d);
    chk("tx_seq_miss", bad_tx, 0);
    chk("busy_done_in_frame", bad_ctl, 0);
  endtask

  task automatic check_end(input int sel);
    chk("done_at_end", done_v[sel], 1'b1);
    chk("busy_at_end", busy_v[sel], 1'b0);
    chk("tx_at_end", tx_v[sel], 1'b1);
    @(negedge clk);
    chk("done_pulse_width", done_v[sel], 1'b0);
  endtask

  typedef struct {
    int         sel;
    logic [7:0] d;
    logic       pe;
    logic       po;
    logic       exp_pb;
    logic       exp_err;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int dones, bad;
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1, 8'hFE, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{0, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0};

    start_v = '0; pe_v = '0; po_v = '0;
    data_v[0] = '0; data_v[1] = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_tx", tx_v[s], 1'b1);
      chk("rst_busy", busy_v[s], 1'b0);
      chk("rst_done", done_v[s], 1'b0);
      chk("rst_par_err", err_v[s], 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table vectors; the first is requested on the very edge after reset release.
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].sel, vecs[i].d, vecs[i].pe, vecs[i].po);
      watch_frame(vecs[i].sel, vecs[i].d, vecs[i].exp_pb, vecs[i].exp_err, -1, 1'b0);
      check_end(vecs[i].sel);
    end

    // Back-to-back: start held high across two frames.
    start_v[0] = 1'b1; data_v[0] = 8'h00; pe_v[0] = 1'b0;
    @(negedge clk);
    data_v[0] = 8'hFF;
    watch_frame(0, 8'h00, 1'b0, 1'b0, -1, 1'b0);
    chk("b2b_done1", done_v[0], 1'b1);
    chk("b2b_busy_kept", busy_v[0], 1'b1);
    chk("b2b_tx_start", tx_v[0], 1'b0);
    start_v[0] = 1'b0;
    watch_frame(0, 8'hFF, 1'b0, 1'b0, -1, 1'b1);
    check_end(0);

    // Start pulsed mid-frame is ignored.
    send(0, 8'hA5, 1'b0, 1'b0);
    watch_frame(0, 8'hA5, 1'b0, 1'b0, 10, 1'b0);
    check_end(0);
    dones = 0; bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (done_v[0] === 1'b1) dones++;
      if (busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("ignored_start_extra_done", dones, 0);
    chk("ignored_start_idle", bad, 0);

    // Reset mid-frame aborts without a done pulse.
    send(0, 8'h3C, 1'b1, 1'b0);
    chk("abort_par_err_set", err_v[0], 1'b1);
    for (int k = 0; k < 20; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_tx", tx_v[0], 1'b1);
    chk("abort_busy", busy_v[0], 1'b0);
    chk("abort_done", done_v[0], 1'b0);
    chk("abort_par_err", err_v[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0; bad = 0;
    for (int k = 0; k < 60; k++) begin
      if (done_v[0] === 1'b1) dones++;
      if (busy_v[0] !== 1'b0 || tx_v[0] !== 1'b1) bad++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);
    chk("abort_idle", bad, 0);

    // Randomized frames against the model.
    for (int i = 0; i < 12; i++) begin
      int sel, gap;
      logic [7:0] d;
      logic pe, po;
      sel = $urandom_range(0, 1);
      gap = $urandom_range(0, 3);
      d = 8'($urandom);
      pe = 1'($urandom);
      po = 1'($urandom);
      for (int g = 0; g < gap; g++) @(negedge clk);
      send(sel, d, pe, po);
      watch_frame(sel, d, model_pb(sel, pe, po), model_err(sel, d, pe, po), -1, 1'b0);
      check_end(sel);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/parity_serializer.md
PARITY_SERIALIZER -- requirements
Module: parity_serializer

Interface
REQ-001 Parameter PARITY_ODD, default 0: 0 selects par_even as the frame parity bit; 1 selects par_odd.
REQ-002 Parameter BIT_CYCLES, default 4: clocks per serial bit, legal range 2..256.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  frame request; sampled on every rising edge.
REQ-006 data_in  input  8  byte to transmit; sampled together with start.
REQ-007 par_even  input  1  even-parity result from the upstream parity stage.
REQ-008 par_odd  input  1  odd-parity result from the upstream parity stage.
REQ-009 tx  output  1  registered serial line; idles high.
REQ-010 busy  output  1  frame in progress.
REQ-011 done  output  1  one-cycle pulse at frame completion.
REQ-012 par_err  output  1  captured parity disagrees with the parity recomputed from data_in.

Function
REQ-013 Frame format: 1 start bit (0), data_in[0]..data_in[7] (LSB first), 1 parity bit, 1 stop bit (1); 11 bits in total.
REQ-014 Each frame bit holds tx constant for exactly BIT_CYCLES clocks, so a frame occupies 11*BIT_CYCLES clocks.
REQ-015 FSM states are IDLE, START, DATA, PARITY and STOP.
REQ-016 IDLE->START occurs on an edge with start=1 and busy=0; that edge captures data_in, the selected parity bit, and par_err; tx goes 0 and busy goes 1 on the same edge.
REQ-017 START->DATA, DATA->PARITY (after the bit index wraps 7->0) and PARITY->STOP each occur when the bit-cycle counter reaches BIT_CYCLES-1.
REQ-018 STOP->IDLE occurs on the edge ending the last STOP cycle; that edge sets busy=0 and done=1, and done returns to 0 on the next edge.
REQ-019 start while busy=1 is ignored, with no queuing; data_in, par_even and par_odd are don't-care while busy=1.
REQ-020 Back-to-back frames: start=1 in the done cycle is accepted, giving 0 idle clocks between the stop bit and the next start bit.
REQ-021 par_err = selected captured parity XOR (^data_in XOR PARITY_ODD), registered at accept and held until the next accept.
REQ-022 The frame is transmitted unchanged when par_err=1; par_err only flags the mismatch.
REQ-023 The bit-cycle counter is ceil(log2(BIT_CYCLES)) bits wide and wraps to 0 at BIT_CYCLES-1; the bit index is 3 bits wide.

Reset
REQ-024 rst_n=0 immediately forces state=IDLE, tx=1, busy=0, done=0, par_err=0, all counters 0, and the captured byte to 0.
REQ-025 Reset asserted mid-frame aborts the frame: tx returns high with no stop bit and no done pulse.
REQ-026 After rst_n deasserts, the first rising edge may accept start.

Structure
REQ-027 The shared package parity_pkg holds the state enum, FRAME_BITS=11, and the START_BIT/STOP_BIT constants.
REQ-028 One sub-module, bit_timer, provides the BIT_CYCLES counter with a tick output.
REQ-029 The serializer FSM and the shift register stay in parity_serializer.

Verification
REQ-030 Scenario: BIT_CYCLES=4, PARITY_ODD=0, data_in=8'hA5, par_even=0, start pulse -> tx sequence 0,1,0,1,0,0,1,0,1,0,1 with each bit held 4 clocks; done at clock 44 after accept; par_err=0.
REQ-031 Scenario: PARITY_ODD=1, data_in=8'hA5, par_odd=1 -> parity bit 1; par_err=0.
REQ-032 Scenario: data_in=8'h01, par_even=0 (wrong) -> par_err=1; frame still sent with parity bit 0.
REQ-033 Scenario: start held high continuously with data 8'h00 then 8'hFF -> two frames with no idle gap; start bit follows the stop bit directly; 2 done pulses, 44 clocks apart.
REQ-034 Scenario: start pulsed at clock 10 of a frame -> ignored, and exactly one done pulse results.
REQ-035 Scenario: rst_n driven low at clock 20 of a frame -> tx=1 and busy=0 immediately, with no done pulse.
